// File: rtl/calc_sequencer_if.sv
// Key/switch inputs and LED-facing outputs of the calculator sequencer.
// The sequencer is the slave; the keypad/LED side (or a bench) is the master.
interface calc_sequencer_if #(
  parameter int OPERAND_W = 5,
  parameter int RESULT_W  = 8
);
  logic                 power_key;
  logic                 enter_key;
  logic [1:0]           op_sel;
  logic [OPERAND_W-1:0] switches;
  logic [3:0]           state;
  logic [OPERAND_W-1:0] number;
  logic                 A;
  logic                 B;
  logic                 C;
  logic [RESULT_W-1:0]  result;
  logic                 Error;
  logic                 PowerOn;
  logic                 busy;

  modport master (
    output power_key, enter_key, op_sel, switches,
    input  state, number, A, B, C, result, Error, PowerOn, busy
  );

  modport slave (
    input  power_key, enter_key, op_sel, switches,
    output state, number, A, B, C, result, Error, PowerOn, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand/op entry, execution (restoring divider),
// result display and timed error display. All outputs are registered.
module calc_sequencer #(
  parameter int ERR_HOLD_CYCLES = 50000000,
  parameter int OPERAND_W       = 5,
  parameter int RESULT_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  calc_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_WAIT_A  = 4'd1,
    S_WAIT_B  = 4'd2,
    S_WAIT_OP = 4'd3,
    S_EXEC    = 4'd4,
    S_DIVIDE  = 4'd5,
    S_RESULT  = 4'd6,
    S_ERROR   = 4'd7
  } state_t;

  localparam int WW = ((2 * OPERAND_W > RESULT_W) ? 2 * OPERAND_W : RESULT_W) + 1;
  localparam int CW = (OPERAND_W > 1) ? $clog2(OPERAND_W) : 1;
  localparam int HW = $clog2(ERR_HOLD_CYCLES);

  state_t               st;
  logic [OPERAND_W-1:0] opa;
  logic [OPERAND_W-1:0] opb;
  logic [1:0]           op;
  logic [OPERAND_W-1:0] quo;
  logic [OPERAND_W-1:0] rem;
  logic [CW-1:0]        cnt;
  logic [HW-1:0]        hold;
  logic [OPERAND_W-1:0] number_q;
  logic                 a_q;
  logic                 b_q;
  logic                 c_q;
  logic [RESULT_W-1:0]  result_q;
  logic                 err_q;
  logic                 pwr_q;
  logic                 busy_q;

  logic [WW-1:0]        wa;
  logic [WW-1:0]        wb;
  logic [WW-1:0]        exec_val;
  logic                 exec_err;
  logic [OPERAND_W:0]   div_shift;
  logic                 div_ge;
  logic [OPERAND_W-1:0] rem_next;
  logic [OPERAND_W-1:0] quo_next;
  logic                 kill;

  // Arithmetic is done wide enough that overflow and borrow show up above RESULT_W.
  always_comb begin
    wa       = WW'(opa);
    wb       = WW'(opb);
    exec_val = '0;
    exec_err = 1'b0;
    case (op)
      2'd0: exec_val = wa + wb;
      2'd1: begin
        exec_val = wa - wb;
        exec_err = (opa < opb);
      end
      2'd2: exec_val = wa * wb;
      default: exec_err = (opb == '0);
    endcase
    if ((exec_val >> RESULT_W) != '0)
      exec_err = 1'b1;
  end

  always_comb begin
    div_shift = {rem, opa[cnt]};
    div_ge    = (div_shift >= {1'b0, opb});
    rem_next  = div_ge ? OPERAND_W'(div_shift - {1'b0, opb}) : div_shift[OPERAND_W-1:0];
    quo_next  = OPERAND_W'({quo, div_ge});
  end

  // Power-off from a running state and illegal codes both fall back to the reset image.
  always_comb begin
    kill = (bus.power_key && (st != S_OFF)) || (st > S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_OFF;
      opa      <= '0;
      opb      <= '0;
      op       <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      hold     <= '0;
      number_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      c_q      <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      pwr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (kill) begin
      st       <= S_OFF;
      opa      <= '0;
      opb      <= '0;
      op       <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      hold     <= '0;
      number_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      c_q      <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      pwr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (st)
        S_OFF: begin
          if (bus.power_key) begin
            st    <= S_WAIT_A;
            pwr_q <= 1'b1;
          end
        end
        S_WAIT_A: begin
          number_q <= bus.switches;
          if (bus.enter_key) begin
            opa <= bus.switches;
            a_q <= 1'b1;
            st  <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          number_q <= bus.switches;
          if (bus.enter_key) begin
            opb <= bus.switches;
            b_q <= 1'b1;
            st  <= S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          number_q <= OPERAND_W'(bus.op_sel);
          if (bus.enter_key) begin
            op     <= bus.op_sel;
            c_q    <= 1'b1;
            busy_q <= 1'b1;
            st     <= S_EXEC;
          end
        end
        S_EXEC: begin
          number_q <= '0;
          if (exec_err) begin
            result_q <= '0;
            err_q    <= 1'b1;
            hold     <= HW'(ERR_HOLD_CYCLES - 1);
            busy_q   <= 1'b0;
            st       <= S_ERROR;
          end else if (op == 2'd3) begin
            quo <= '0;
            rem <= '0;
            cnt <= CW'(OPERAND_W - 1);
            st  <= S_DIVIDE;
          end else begin
            result_q <= RESULT_W'(exec_val);
            busy_q   <= 1'b0;
            st       <= S_RESULT;
          end
        end
        S_DIVIDE: begin
          quo <= quo_next;
          rem <= rem_next;
          if (cnt == '0) begin
            result_q <= RESULT_W'(quo_next);
            busy_q   <= 1'b0;
            st       <= S_RESULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESULT: begin
          number_q <= '0;
          if (bus.enter_key) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
            result_q <= '0;
            st       <= S_WAIT_A;
          end
        end
        S_ERROR: begin
          number_q <= '0;
          if (bus.enter_key || (hold == '0)) begin
            err_q <= 1'b0;
            a_q   <= 1'b0;
            b_q   <= 1'b0;
            c_q   <= 1'b0;
            st    <= S_WAIT_A;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        default: st <= S_OFF;
      endcase
    end
  end

  assign bus.state   = st;
  assign bus.number  = number_q;
  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.C       = c_q;
  assign bus.result  = result_q;
  assign bus.Error   = err_q;
  assign bus.PowerOn = pwr_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed and randomized checks of calc_sequencer against an arithmetic reference model.
module tb_calc_sequencer;
  localparam int OW   = 5;
  localparam int RW   = 8;
  localparam int HOLD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  calc_sequencer_if #(.OPERAND_W(OW), .RESULT_W(RW)) bus ();

  calc_sequencer #(
    .ERR_HOLD_CYCLES(HOLD),
    .OPERAND_W      (OW),
    .RESULT_W       (RW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press_enter();
    bus.enter_key = 1'b1;
    @(negedge clk);
    bus.enter_key = 1'b0;
  endtask

  task automatic press_power();
    bus.power_key = 1'b1;
    @(negedge clk);
    bus.power_key = 1'b0;
  endtask

  function automatic void model(input int a, input int b, input int op,
                                output int val, output bit err);
    err = 1'b0;
    val = 0;
    case (op)
      0: val = a + b;
      1: val = a - b;
      2: val = a * b;
      default: if (b == 0) err = 1'b1; else val = a / b;
    endcase
    if (val < 0 || val > (1 << RW) - 1) err = 1'b1;
    if (err) val = 0;
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, "_state"},   32'(bus.state),   0);
    chk({tag, "_number"},  32'(bus.number),  0);
    chk({tag, "_A"},       32'(bus.A),       0);
    chk({tag, "_B"},       32'(bus.B),       0);
    chk({tag, "_C"},       32'(bus.C),       0);
    chk({tag, "_result"},  32'(bus.result),  0);
    chk({tag, "_Error"},   32'(bus.Error),   0);
    chk({tag, "_PowerOn"}, 32'(bus.PowerOn), 0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
  endtask

  // Enter a, b, op from WAIT_A and follow the calculation back to WAIT_A.
  task automatic run_op(input int a, input int b, input int op, input bit exit_by_enter);
    int val;
    bit err;
    model(a, b, op, val, err);
    bus.switches = OW'(a);
    cyc();
    chk("state_wait_a", 32'(bus.state), 1);
    chk("echo_a", 32'(bus.number), a);
    press_enter();
    chk("state_wait_b", 32'(bus.state), 2);
    chk("flag_a", 32'(bus.A), 1);
    bus.switches = OW'(b);
    cyc();
    chk("echo_b", 32'(bus.number), b);
    press_enter();
    chk("state_wait_op", 32'(bus.state), 3);
    chk("flag_b", 32'(bus.B), 1);
    bus.op_sel = 2'(op);
    cyc();
    chk("echo_op", 32'(bus.number), op);
    press_enter();
    chk("state_exec", 32'(bus.state), 4);
    chk("flag_c", 32'(bus.C), 1);
    chk("busy_exec", 32'(bus.busy), 1);
    bus.switches = OW'($urandom);
    bus.op_sel   = 2'($urandom);
    if (op == 3 && !err) begin
      for (int k = 0; k < OW; k++) begin
        cyc();
        chk("state_divide", 32'(bus.state), 5);
        chk("busy_divide", 32'(bus.busy), 1);
      end
    end
    cyc();
    if (!err) begin
      chk("state_result", 32'(bus.state), 6);
      chk("result", 32'(bus.result), val);
      chk("error_clear", 32'(bus.Error), 0);
      chk("busy_result", 32'(bus.busy), 0);
      chk("abc_result", {29'd0, bus.A, bus.B, bus.C}, 7);
      chk("number_result", 32'(bus.number), 0);
      press_enter();
      chk("state_back", 32'(bus.state), 1);
      chk("abc_back", {29'd0, bus.A, bus.B, bus.C}, 0);
      chk("result_cleared", 32'(bus.result), 0);
    end else begin
      chk("state_error", 32'(bus.state), 7);
      chk("error_set", 32'(bus.Error), 1);
      chk("result_error", 32'(bus.result), 0);
      chk("busy_error", 32'(bus.busy), 0);
      if (exit_by_enter) begin
        press_enter();
      end else begin
        for (int k = 0; k < HOLD - 1; k++) begin
          cyc();
          chk("state_error_hold", 32'(bus.state), 7);
        end
        cyc();
      end
      chk("state_err_back", 32'(bus.state), 1);
      chk("error_cleared", 32'(bus.Error), 0);
      chk("abc_err_back", {29'd0, bus.A, bus.B, bus.C}, 0);
    end
  endtask

  initial begin
    bus.power_key = 1'b0;
    bus.enter_key = 1'b0;
    bus.op_sel    = 2'd0;
    bus.switches  = '0;
    cyc();
    cyc();
    check_cleared("reset");
    reset = 1'b0;

    press_enter();
    chk("enter_ignored_off", 32'(bus.state), 0);
    press_power();
    chk("power_on_state", 32'(bus.state), 1);
    chk("power_on_flag", 32'(bus.PowerOn), 1);

    run_op(12, 7, 0, 1'b0);
    run_op(5, 9, 1, 1'b0);
    run_op(5, 9, 1, 1'b1);
    run_op(31, 31, 2, 1'b1);
    run_op(15, 17, 2, 1'b0);
    run_op(29, 4, 3, 1'b0);
    run_op(9, 0, 3, 1'b0);
    run_op(31, 1, 3, 1'b1);
    run_op(20, 20, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int a, b, op;
      a  = int'($urandom_range(0, 31));
      b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 31));
      op = int'($urandom_range(0, 3));
      run_op(a, b, op, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a division.
    bus.switches = 5'd29;
    cyc();
    press_enter();
    bus.switches = 5'd4;
    cyc();
    press_enter();
    bus.op_sel = 2'd3;
    cyc();
    press_enter();
    cyc();
    cyc();
    chk("div_before_reset", 32'(bus.state), 5);
    #1 reset = 1'b1;
    #1;
    check_cleared("async_reset");
    reset = 1'b0;
    cyc();
    chk("off_after_reset", 32'(bus.state), 0);
    press_power();
    chk("power_after_reset", 32'(bus.state), 1);

    // power_key beats enter_key in WAIT_B.
    bus.switches = 5'd3;
    cyc();
    press_enter();
    chk("wait_b_again", 32'(bus.state), 2);
    bus.power_key = 1'b1;
    bus.enter_key = 1'b1;
    cyc();
    bus.power_key = 1'b0;
    bus.enter_key = 1'b0;
    check_cleared("power_priority");
    press_power();
    chk("repower_state", 32'(bus.state), 1);
    chk("repower_flag", 32'(bus.PowerOn), 1);
    run_op(6, 3, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
